// File: rtl/xctcmsg_pkg.sv
// Shared types for the xctcmsg unit: the receive-side message record and the
// mailbox receive FSM state encoding.
package xctcmsg_pkg;

  typedef struct packed {
    logic [7:0]  src_addr;
    logic [31:0] payload;
  } interface_receive_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mailbox_state_t;

endpackage

// File: rtl/mailbox_fifo.sv
// Generic in-order synchronous FIFO with power-of-two depth, naturally
// wrapping pointers and an occupancy counter. The head entry is always
// presented on head_data. The caller is responsible for never pushing when
// full or popping when empty.
module mailbox_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;

  // Storage write; entries need no reset because count gates their visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[tail_r] <= push_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop) begin
        head_r <= head_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[head_r];
  assign count     = count_r;

endmodule

// File: rtl/mailbox.sv
// Receive-side mailbox: buffers incoming messages in a FIFO and serves them
// to the core's receive instruction through a request/response handshake.
// A blocked receive (WAIT) can be cancelled with core_mailbox_kill; once a
// message has been popped into the response register it is always delivered.
module mailbox
  import xctcmsg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       loopback_mailbox_valid,
  output logic                       mailbox_loopback_ready,
  input  interface_receive_data_t    loopback_mailbox_data,
  input  logic                       core_mailbox_valid,
  output logic                       mailbox_core_ready,
  input  logic                       core_mailbox_kill,
  output logic                       mailbox_core_valid,
  input  logic                       core_mailbox_ready,
  output interface_receive_data_t    mailbox_core_data,
  output logic [$clog2(DEPTH+1)-1:0] mailbox_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $bits(interface_receive_data_t);

  mailbox_state_t          state_r;
  mailbox_state_t          next_state_s;
  logic                    push_s;
  logic                    pop_s;
  logic [CW-1:0]           count_s;
  logic [DW-1:0]           head_data_s;
  logic                    resp_valid_r;
  logic                    core_ready_r;
  interface_receive_data_t resp_data_r;

  // Full is judged on the registered count only: no same-cycle pop passthrough.
  assign mailbox_loopback_ready = (count_s != CW'(DEPTH));
  assign push_s                 = loopback_mailbox_valid & mailbox_loopback_ready;

  mailbox_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (loopback_mailbox_data),
    .pop       (pop_s),
    .head_data (head_data_s),
    .count     (count_s)
  );

  // Receive FSM next-state and pop decision; kill only matters while blocked in WAIT.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (core_mailbox_valid) begin
          if (count_s != CW'(0)) begin
            pop_s        = 1'b1;
            next_state_s = RESP;
          end else begin
            next_state_s = WAIT;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (core_mailbox_kill) begin
          next_state_s = IDLE;
        end else if (count_s != CW'(0)) begin
          pop_s        = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: begin
        if (core_mailbox_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, handshake flags and response register, all cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      resp_valid_r <= 1'b0;
      core_ready_r <= 1'b1;
      resp_data_r  <= '0;
    end else begin
      state_r      <= next_state_s;
      resp_valid_r <= (next_state_s == RESP);
      core_ready_r <= (next_state_s == IDLE);
      if (pop_s) begin
        resp_data_r <= interface_receive_data_t'(head_data_s);
      end
    end
  end

  assign mailbox_core_ready = core_ready_r;
  assign mailbox_core_valid = resp_valid_r;
  assign mailbox_core_data  = resp_data_r;
  assign mailbox_count      = count_s;

endmodule

// File: tb/tb_mailbox.sv
// Directed bench for mailbox: a table of per-cycle vectors with hand-computed
// post-edge expectations, plus a hand-written asynchronous reset sequence.
module tb_mailbox;
  import xctcmsg_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    loopback_mailbox_valid;
  logic                    mailbox_loopback_ready;
  interface_receive_data_t loopback_mailbox_data;
  logic                    core_mailbox_valid;
  logic                    mailbox_core_ready;
  logic                    core_mailbox_kill;
  logic                    mailbox_core_valid;
  logic                    core_mailbox_ready;
  interface_receive_data_t mailbox_core_data;
  logic [2:0]              mailbox_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       lv;
    logic [7:0] ls;
    logic       cv;
    logic       ck;
    logic       cr;
    logic       e_lr;
    logic       e_cr;
    logic       e_cv;
    logic [7:0] e_src;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  mailbox #(.DEPTH(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .loopback_mailbox_valid (loopback_mailbox_valid),
    .mailbox_loopback_ready (mailbox_loopback_ready),
    .loopback_mailbox_data  (loopback_mailbox_data),
    .core_mailbox_valid     (core_mailbox_valid),
    .mailbox_core_ready     (mailbox_core_ready),
    .core_mailbox_kill      (core_mailbox_kill),
    .mailbox_core_valid     (mailbox_core_valid),
    .core_mailbox_ready     (core_mailbox_ready),
    .mailbox_core_data      (mailbox_core_data),
    .mailbox_count          (mailbox_count)
  );

  always #5 clk = ~clk;

  function automatic interface_receive_data_t mk_data(input logic [7:0] src);
    interface_receive_data_t d;
    d.src_addr = src;
    d.payload  = {24'hA5C300, src};
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic lv, input logic [7:0] ls, input logic cv, input logic ck,
                     input logic cr, input logic e_lr, input logic e_cr, input logic e_cv,
                     input logic [7:0] e_src, input logic [2:0] e_cnt);
    vec_t v;
    v.lv = lv; v.ls = ls; v.cv = cv; v.ck = ck; v.cr = cr;
    v.e_lr = e_lr; v.e_cr = e_cr; v.e_cv = e_cv; v.e_src = e_src; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic lv, input logic [7:0] ls, input logic cv,
                       input logic ck, input logic cr);
    loopback_mailbox_valid = lv;
    loopback_mailbox_data  = mk_data(ls);
    core_mailbox_valid     = cv;
    core_mailbox_kill      = ck;
    core_mailbox_ready     = cr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    //   lv    ls     cv    ck    cr    e_lr  e_cr  e_cv  e_src  e_cnt
    // fill 1..4, hold a 5th while full
    add(1'b1, 8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    add(1'b1, 8'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd2);
    add(1'b1, 8'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd3);
    add(1'b1, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd4);
    add(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd4);
    // request pops 1 while 5 is blocked (no full passthrough)
    add(1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1,  3'd3);
    // handshake; 5 accepted the cycle after the pop
    add(1'b1, 8'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  3'd4);
    // drain 2,3,4,5 with back-to-back request/handshake
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2,  3'd3);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd3);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3,  3'd2);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd2);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4,  3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5,  3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd0);
    // request on empty at N, push 5 at N+4, valid at N+6
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'd0);
    add(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5,  3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd0);
    // 7,8 buffered; response held 3 cycles, kill ignored in RESP
    add(1'b1, 8'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    add(1'b1, 8'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd2);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7,  3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7,  3'd1);
    add(1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7,  3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7,  3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd8,  3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd0);
    // kill in WAIT beats a simultaneous push of 9
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'd0);
    add(1'b1, 8'd9,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    // kill ignored in IDLE: request still returns 9
    add(1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd9,  3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd0);
    // push and pop in the same cycle leave count unchanged
    add(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    add(1'b1, 8'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd10, 3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd1);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd11, 3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd0);
    // no bypass: request and push together on empty goes to WAIT first
    add(1'b1, 8'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd12, 3'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  3'd0);

    // reset values
    #2;
    chk("reset_ctl", {mailbox_loopback_ready, mailbox_core_ready, mailbox_core_valid, mailbox_count},
        {1'b1, 1'b1, 1'b0, 3'd0});
    chk("reset_data", mailbox_core_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lv, vecs[i].ls, vecs[i].cv, vecs[i].ck, vecs[i].cr);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i),
          {mailbox_loopback_ready, mailbox_core_ready, mailbox_core_valid, mailbox_count},
          {vecs[i].e_lr, vecs[i].e_cr, vecs[i].e_cv, vecs[i].e_cnt});
      if (vecs[i].e_cv) begin
        chk($sformatf("vec%0d_data", i), mailbox_core_data, mk_data(vecs[i].e_src));
      end
    end

    // reset asserted mid-RESP with two messages still buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(20 + i), 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_ctl", {mailbox_core_valid, mailbox_count}, {1'b1, 3'd2});
    chk("pre_rst_data", mailbox_core_data, mk_data(8'd20));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {mailbox_loopback_ready, mailbox_core_ready, mailbox_core_valid, mailbox_count},
        {1'b1, 1'b1, 1'b0, 3'd0});
    chk("mid_rst_data", mailbox_core_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_wait", {mailbox_core_ready, mailbox_core_valid, mailbox_count}, {1'b0, 1'b0, 3'd0});
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_kill", {mailbox_core_ready, mailbox_core_valid}, {1'b1, 1'b0});
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
